// File: rtl/ram_seq_writer_pkg.sv
// ram_seq_writer_pkg
//   Shared definitions for the sequential RAM writer:
//   - default memory geometry (DEPTH / AW / DW) matching the existing 32x4 dual-port RAM
//   - FSM state encoding used by ram_seq_writer
package ram_seq_writer_pkg;

    // Default geometry of the attached RAM write port.
    localparam int unsigned DEPTH_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT    = 5;
    localparam int unsigned DW_DEFAULT    = 4;

    // Writer FSM states: idle (single stores / pointer loads), full-memory fill,
    // and the one-cycle completion state that pulses done.
    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFill = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/edge_rise.sv
// edge_rise
//   Rising-edge detector built on a registered previous sample.
//   The previous-sample register resets to 1, so a level that is already high while
//   reset is released is not reported as an edge; it must fall and rise again.
//
// Ports
//   clk  : clock
//   rst  : synchronous, active-high reset
//   sig  : level input (already synchronised to clk)
//   rise : high while sig is 1 and the previous sample was 0
module edge_rise (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig;
        end
    end

    // Consumed only by registered logic in the parent, so this stays off any output path.
    assign rise = sig & ~prev_q;

endmodule

// File: rtl/ram_seq_writer.sv
// ram_seq_writer
//   Drives the write port of an external RAM. In idle, a rising edge on store writes
//   wr_data at the write pointer and advances the pointer (modulo DEPTH); a rising edge
//   on load_addr reloads the pointer from start_addr. A rising edge on fill writes
//   fill_data to every address 0..DEPTH-1 on consecutive cycles, then pulses done for
//   one cycle and clears the pointer. All outputs are registered.
//
// Parameters
//   DEPTH : number of memory words (power of two)
//   AW    : address width, log2(DEPTH)
//   DW    : data width
//
// Ports
//   clk        : single clock
//   rst        : synchronous, active-high reset (highest priority)
//   wr_data    : word written by a single store
//   start_addr : value loaded into the write pointer
//   load_addr  : level; pointer load on rising edge
//   store      : level; one write per rising edge
//   fill       : level; full-memory fill on rising edge
//   fill_data  : fill pattern, captured on the fill edge
//   mem_we     : RAM write enable
//   mem_addr   : RAM write address (held while mem_we=0)
//   mem_data   : RAM write data (held while mem_we=0)
//   wr_ptr     : current write pointer
//   busy       : high on every fill write cycle
//   done       : one-cycle pulse after the last fill write
module ram_seq_writer
    import ram_seq_writer_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned AW    = AW_DEFAULT,
    parameter int unsigned DW    = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] start_addr,
    input  logic          load_addr,
    input  logic          store,
    input  logic          fill,
    input  logic [DW-1:0] fill_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic [AW-1:0] wr_ptr,
    output logic          busy,
    output logic          done
);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

    state_e        state_q;
    logic          load_rise;
    logic          store_rise;
    logic          fill_rise;
    logic [AW-1:0] store_addr;

    edge_rise u_load_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (load_addr),
        .rise (load_rise)
    );

    edge_rise u_store_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (store),
        .rise (store_rise)
    );

    edge_rise u_fill_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (fill),
        .rise (fill_rise)
    );

    // A load coinciding with a store redirects that store to start_addr, so the
    // pointer ends up at start_addr+1.
    assign store_addr = load_rise ? start_addr : wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            wr_ptr   <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            // Write enable and done are single-cycle unless a branch re-asserts them.
            mem_we <= 1'b0;
            done   <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (fill_rise) begin
                        // Fill wins over any coincident store/load; those are dropped.
                        // mem_data keeps the captured pattern for the whole fill.
                        state_q  <= StFill;
                        busy     <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= '0;
                        mem_data <= fill_data;
                    end else if (store_rise) begin
                        mem_we   <= 1'b1;
                        mem_addr <= store_addr;
                        mem_data <= wr_data;
                        wr_ptr   <= store_addr + 1'b1;
                    end else if (load_rise) begin
                        wr_ptr <= start_addr;
                    end
                end

                StFill: begin
                    // Edges arriving here are ignored; the detectors still track the
                    // inputs, so nothing is replayed once idle again.
                    if (mem_addr == LastAddr) begin
                        state_q <= StDone;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        wr_ptr  <= '0;
                    end else begin
                        mem_we   <= 1'b1;
                        mem_addr <= mem_addr + 1'b1;
                    end
                end

                StDone: begin
                    state_q <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
